// File: rtl/inst_encoder_loader_pkg.sv
// Shared opcodes, format/state enums and immediate range helper for the
// instruction encoder/loader.
package inst_enc_pkg;

    localparam logic [6:0] OP_JAL    = 7'b110_1111;
    localparam logic [6:0] OP_STORE  = 7'b010_0011;
    localparam logic [6:0] OP_BRANCH = 7'b110_0011;
    localparam logic [6:0] OP_LOAD   = 7'b000_0011;
    localparam logic [6:0] OP_IMM    = 7'b001_0011;
    localparam logic [6:0] OP_JALR   = 7'b110_0111;

    typedef enum logic [2:0] {FMT_I, FMT_S, FMT_B, FMT_J, FMT_BAD} fmt_e;
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;

    function automatic fmt_e op_fmt(input logic [6:0] op);
        fmt_e f;
        case (op)
            OP_IMM, OP_LOAD, OP_JALR: f = FMT_I;
            OP_STORE:                 f = FMT_S;
            OP_BRANCH:                f = FMT_B;
            OP_JAL:                   f = FMT_J;
            default:                  f = FMT_BAD;
        endcase
        return f;
    endfunction

    // True when imm[31:msb] are all copies of the sign bit.
    function automatic logic imm_fits(input logic [31:0] imm, input logic [4:0] msb);
        logic [31:0] sh;
        sh = $signed(imm) >>> msb;
        return (sh == 32'h0000_0000) || (sh == 32'hFFFF_FFFF);
    endfunction

endpackage

// File: rtl/inst_encoder_loader_field_pack.sv
// Combinational RV32 field packer: builds the instruction word from opcode,
// register fields and immediate, and flags immediates that do not fit.
module inst_field_pack
    import inst_enc_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        ok
);

    fmt_e        fmt_s;
    logic [31:0] word_s;
    logic        ok_s;

    // Format-specific packing and range check
    always_comb begin
        fmt_s  = op_fmt(opcode);
        word_s = 32'h0000_0000;
        ok_s   = 1'b0;
        case (fmt_s)
            FMT_I: begin
                word_s = {imm[11:0], rs1, funct3, rd, opcode};
                ok_s   = imm_fits(imm, 5'd11);
            end
            FMT_S: begin
                word_s = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                ok_s   = imm_fits(imm, 5'd11);
            end
            FMT_B: begin
                word_s = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                ok_s   = imm_fits(imm, 5'd12) && (imm[0] == 1'b0);
            end
            FMT_J: begin
                word_s = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                ok_s   = imm_fits(imm, 5'd20) && (imm[0] == 1'b0);
            end
            default: begin
                word_s = 32'h0000_0000;
                ok_s   = 1'b0;
            end
        endcase
    end

    assign word = word_s;
    assign ok   = ok_s;

endmodule

// File: rtl/inst_encoder_loader.sv
// Loads a run of encoded RV32 instruction words into instruction memory at
// consecutive word addresses, dropping and counting out-of-range entries.
module inst_encoder_loader
    import inst_enc_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 8
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  n_words,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [31:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  err_cnt
);

    state_e            state_r, state_s;
    logic [ADDR_W-1:0] ptr_r;
    logic [CNT_W-1:0]  rem_r;
    logic              in_ready_r, busy_r, done_r, err_r;
    logic [CNT_W-1:0]  err_cnt_r;
    logic              imem_we_r;
    logic [ADDR_W-1:0] imem_addr_r;
    logic [31:0]       imem_wdata_r;
    logic              hs_s, load_s, ok_s;
    logic [31:0]       word_s;

    inst_field_pack u_pack (
        .opcode (in_opcode),
        .rd     (in_rd),
        .rs1    (in_rs1),
        .rs2    (in_rs2),
        .funct3 (in_funct3),
        .imm    (in_imm),
        .word   (word_s),
        .ok     (ok_s)
    );

    // Handshake and run-start qualifiers
    always_comb begin
        hs_s   = in_valid & in_ready_r;
        load_s = (state_r == IDLE) & start;
    end

    // Next-state selection
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (n_words == {CNT_W{1'b0}}) state_s = DONE;
                    else                          state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (hs_s && (rem_r == CNT_W'(1))) state_s = FLUSH;
                else                              state_s = RUN;
            end
            FLUSH:   state_s = DONE;
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register; status outputs are registered from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            in_ready_r <= (state_s == RUN);
            busy_r     <= (state_s != IDLE);
            done_r     <= (state_s == DONE);
        end
    end

    // Write pointer, remaining count and per-run error accounting
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_r     <= {ADDR_W{1'b0}};
            rem_r     <= {CNT_W{1'b0}};
            err_r     <= 1'b0;
            err_cnt_r <= {CNT_W{1'b0}};
        end else if (load_s) begin
            ptr_r     <= base_addr;
            rem_r     <= n_words;
            err_r     <= 1'b0;
            err_cnt_r <= {CNT_W{1'b0}};
        end else if (hs_s) begin
            rem_r <= rem_r - CNT_W'(1);
            if (ok_s) begin
                ptr_r <= ptr_r + ADDR_W'(1);
            end else begin
                err_r <= 1'b1;
                if (err_cnt_r != {CNT_W{1'b1}}) err_cnt_r <= err_cnt_r + CNT_W'(1);
            end
        end
    end

    // Stage-2 instruction-memory write register; address/data hold between writes
    always_ff @(posedge clk) begin
        if (reset) begin
            imem_we_r    <= 1'b0;
            imem_addr_r  <= {ADDR_W{1'b0}};
            imem_wdata_r <= 32'h0000_0000;
        end else begin
            imem_we_r <= hs_s & ok_s;
            if (hs_s & ok_s) begin
                imem_addr_r  <= ptr_r;
                imem_wdata_r <= word_s;
            end
        end
    end

    assign in_ready   = in_ready_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;
    assign err_cnt    = err_cnt_r;
    assign imem_we    = imem_we_r;
    assign imem_addr  = imem_addr_r;
    assign imem_wdata = imem_wdata_r;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Self-checking bench for inst_encoder_loader: directed plan vectors plus
// randomized runs against a range-based reference model and an immediate decoder.
module tb_inst_encoder_loader;

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [31:0] imm;
    } desc_t;

    typedef struct {
        int          cyc;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] imm;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  base_addr = 8'h00;
    logic [7:0]  n_words = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_opcode = 7'h00;
    logic [4:0]  in_rd = 5'h00;
    logic [4:0]  in_rs1 = 5'h00;
    logic [4:0]  in_rs2 = 5'h00;
    logic [2:0]  in_funct3 = 3'h0;
    logic [31:0] in_imm = 32'h0;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        busy, done, err;
    logic [7:0]  err_cnt;

    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    wr_t   obs_q[$];
    wr_t   last_exp_q[$];
    desc_t stim_q[$];

    inst_encoder_loader #(.ADDR_W(8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .n_words(n_words), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_imm(in_imm), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .busy(busy),
        .done(done), .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Records every memory write seen mid-cycle.
    always @(negedge clk) begin
        wr_t w;
        if (imem_we === 1'b1) begin
            w.cyc  = cyc;
            w.addr = imem_addr;
            w.data = imem_wdata;
            w.imm  = 32'h0;
            obs_q.push_back(w);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept/reject decided from numeric ranges of the immediate.
    function automatic logic ref_ok(input desc_t d);
        longint s;
        s = longint'($signed(d.imm));
        case (d.op)
            7'b001_0011, 7'b000_0011, 7'b110_0111, 7'b010_0011:
                return (s >= -64'sd2048) && (s <= 64'sd2047);
            7'b110_0011:
                return (s >= -64'sd4096) && (s <= 64'sd4095) && (d.imm[0] == 1'b0);
            7'b110_1111:
                return (s >= -64'sd1048576) && (s <= 64'sd1048575) && (d.imm[0] == 1'b0);
            default:
                return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_word(input desc_t d);
        logic [31:0] i;
        i = d.imm;
        case (d.op)
            7'b010_0011: return {i[11:5], d.rs2, d.rs1, d.f3, i[4:0], d.op};
            7'b110_0011: return {i[12], i[10:5], d.rs2, d.rs1, d.f3, i[4:1], i[11], d.op};
            7'b110_1111: return {i[20], i[10:1], i[11], i[19:12], d.rd, d.op};
            default:     return {i[11:0], d.rs1, d.f3, d.rd, d.op};
        endcase
    endfunction

    // Immediate decoder: recovers the immediate from an encoded word.
    function automatic logic [31:0] ref_dec(input logic [31:0] w);
        case (w[6:0])
            7'b010_0011: return {{20{w[31]}}, w[31:25], w[11:7]};
            7'b110_0011: return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            7'b110_1111: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default:     return {{20{w[31]}}, w[31:20]};
        endcase
    endfunction

    function automatic desc_t mk(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
        desc_t d;
        d.op = op; d.rd = rd; d.rs1 = rs1; d.rs2 = rs2; d.f3 = f3; d.imm = imm;
        return d;
    endfunction

    function automatic desc_t rand_desc();
        logic [6:0]  ops [7];
        logic [31:0] r;
        desc_t       d;
        ops = '{7'b001_0011, 7'b000_0011, 7'b110_0111, 7'b010_0011,
                7'b110_0011, 7'b110_1111, 7'b011_0011};
        r = $urandom;
        d.op  = ops[$urandom_range(0, 6)];
        d.rd  = 5'($urandom);
        d.rs1 = 5'($urandom);
        d.rs2 = 5'($urandom);
        d.f3  = 3'($urandom);
        case ($urandom_range(0, 3))
            1:       d.imm = {{20{r[11]}}, r[11:0]};
            2:       d.imm = {{19{r[12]}}, r[12:0]};
            3:       d.imm = {{11{r[20]}}, r[20:0]};
            default: d.imm = r;
        endcase
        return d;
    endfunction

    // Drives stim_q as one run and checks writes, timing, status and done pulse.
    task automatic do_run(input logic [7:0] base, input string tag, input bit poke_start);
        logic [7:0] ptr;
        int         errs;
        int         bound;
        int         dn;
        wr_t        exp_q[$];
        wr_t        e;
        obs_q.delete();
        ptr  = base;
        errs = 0;
        start = 1'b1; base_addr = base; n_words = 8'(stim_q.size());
        tick();
        start = poke_start;
        base_addr = base + 8'h40;
        n_words = 8'h05;
        check({tag, " busy"}, 64'(busy), 64'd1);
        foreach (stim_q[i]) begin
            in_opcode = stim_q[i].op; in_rd = stim_q[i].rd; in_rs1 = stim_q[i].rs1;
            in_rs2 = stim_q[i].rs2; in_funct3 = stim_q[i].f3; in_imm = stim_q[i].imm;
            in_valid = 1'b1;
            bound = 0;
            while (in_ready !== 1'b1 && bound < 20) begin
                tick();
                bound++;
            end
            check({tag, " ready wait"}, 64'(bound), 64'd0);
            tick();
            if (ref_ok(stim_q[i])) begin
                e.cyc = cyc; e.addr = ptr; e.data = ref_word(stim_q[i]); e.imm = stim_q[i].imm;
                exp_q.push_back(e);
                ptr = ptr + 8'd1;
            end else begin
                errs++;
            end
        end
        in_valid = 1'b0;
        start = 1'b0;
        check({tag, " ready low after last"}, 64'(in_ready), 64'd0);
        dn = 0;
        for (int k = 0; k < 6; k++) begin
            if (done === 1'b1) dn++;
            tick();
        end
        check({tag, " done pulses"}, 64'(dn), 64'd1);
        check({tag, " busy end"}, 64'(busy), 64'd0);
        check({tag, " err"}, 64'(err), 64'(errs != 0));
        check({tag, " err_cnt"}, 64'(err_cnt), 64'(errs));
        check({tag, " write count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check({tag, " write cycle"}, 64'(obs_q[i].cyc), 64'(exp_q[i].cyc));
            check({tag, " write addr"}, 64'(obs_q[i].addr), 64'(exp_q[i].addr));
            check({tag, " write data"}, 64'(obs_q[i].data), 64'(exp_q[i].data));
            check({tag, " decode imm"}, 64'(ref_dec(obs_q[i].data)), 64'(exp_q[i].imm));
        end
        last_exp_q = exp_q;
    endtask

    initial begin
        int n;
        // Reset state
        reset = 1'b1;
        tick(); tick();
        check("reset in_ready", 64'(in_ready), 64'd0);
        check("reset imem_we", 64'(imem_we), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset err", 64'(err), 64'd0);
        check("reset err_cnt", 64'(err_cnt), 64'd0);
        check("reset addr", 64'(imem_addr), 64'd0);
        check("reset wdata", 64'(imem_wdata), 64'd0);
        reset = 1'b0;
        tick();

        // Single I-type word
        stim_q.delete();
        stim_q.push_back(mk(7'b001_0011, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5));
        do_run(8'h10, "single", 1'b0);
        n = obs_q.size();
        check("single count", 64'(n), 64'd1);
        if (n > 0) begin
            check("single word", 64'(obs_q[0].data), 64'h0050_0093);
            check("single addr", 64'(obs_q[0].addr), 64'h10);
        end

        // Back-to-back S, B, J
        stim_q.delete();
        stim_q.push_back(mk(7'b010_0011, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8));
        stim_q.push_back(mk(7'b110_0011, 5'd0, 5'd0, 5'd0, 3'd0, 32'hFFFF_FFFC));
        stim_q.push_back(mk(7'b110_1111, 5'd1, 5'd0, 5'd0, 3'd0, 32'd8));
        do_run(8'h10, "b2b", 1'b0);
        n = obs_q.size();
        check("b2b count", 64'(n), 64'd3);
        if (n == 3) begin
            check("b2b S word", 64'(obs_q[0].data), 64'h0020_A423);
            check("b2b B word", 64'(obs_q[1].data), 64'hFE00_0EE3);
            check("b2b J word", 64'(obs_q[2].data), 64'h0080_00EF);
            check("b2b J addr", 64'(obs_q[2].addr), 64'h12);
            check("b2b consecutive", 64'(obs_q[2].cyc - obs_q[0].cyc), 64'd2);
        end

        // Range errors
        stim_q.delete();
        stim_q.push_back(mk(7'b001_0011, 5'd3, 5'd4, 5'd0, 3'd0, 32'd2048));
        stim_q.push_back(mk(7'b110_0011, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3));
        stim_q.push_back(mk(7'b011_0011, 5'd1, 5'd2, 5'd3, 3'd0, 32'd0));
        do_run(8'h10, "errors", 1'b0);
        check("errors err_cnt abs", 64'(err_cnt), 64'd3);
        check("errors sticky in idle", 64'(err), 64'd1);

        // Format boundaries
        stim_q.delete();
        stim_q.push_back(mk(7'b001_0011, 5'd1, 5'd2, 5'd0, 3'd1, 32'd2047));
        stim_q.push_back(mk(7'b000_0011, 5'd1, 5'd2, 5'd0, 3'd2, 32'hFFFF_F800));
        stim_q.push_back(mk(7'b110_0111, 5'd1, 5'd2, 5'd0, 3'd0, 32'hFFFF_F7FF));
        stim_q.push_back(mk(7'b010_0011, 5'd0, 5'd2, 5'd3, 3'd2, 32'hFFFF_F800));
        stim_q.push_back(mk(7'b110_0011, 5'd0, 5'd4, 5'd5, 3'd1, 32'd4094));
        stim_q.push_back(mk(7'b110_0011, 5'd0, 5'd4, 5'd5, 3'd1, 32'hFFFF_F000));
        stim_q.push_back(mk(7'b110_0011, 5'd0, 5'd4, 5'd5, 3'd1, 32'd4096));
        stim_q.push_back(mk(7'b110_1111, 5'd7, 5'd0, 5'd0, 3'd0, 32'd1048574));
        stim_q.push_back(mk(7'b110_1111, 5'd7, 5'd0, 5'd0, 3'd0, 32'hFFF0_0000));
        stim_q.push_back(mk(7'b110_1111, 5'd7, 5'd0, 5'd0, 3'd0, 32'd1048576));
        do_run(8'h50, "bounds", 1'b0);
        check("bounds err_cnt abs", 64'(err_cnt), 64'd3);

        // Zero-length run
        obs_q.delete();
        start = 1'b1; base_addr = 8'h30; n_words = 8'h00;
        tick();
        start = 1'b0;
        check("zero busy", 64'(busy), 64'd1);
        check("zero done", 64'(done), 64'd1);
        check("zero ready", 64'(in_ready), 64'd0);
        check("zero err cleared", 64'(err), 64'd0);
        tick();
        check("zero busy after", 64'(busy), 64'd0);
        check("zero done after", 64'(done), 64'd0);
        check("zero ready after", 64'(in_ready), 64'd0);
        check("zero no writes", 64'(obs_q.size()), 64'd0);

        // start held during RUN must not disturb the run
        stim_q.delete();
        stim_q.push_back(mk(7'b001_0011, 5'd2, 5'd3, 5'd0, 3'd0, 32'd100));
        stim_q.push_back(mk(7'b001_0011, 5'd2, 5'd3, 5'd0, 3'd0, 32'hFFFF_FFFF));
        do_run(8'h20, "start in run", 1'b1);
        check("start in run idle", 64'(busy), 64'd0);

        // Pointer wrap
        stim_q.delete();
        stim_q.push_back(mk(7'b001_0011, 5'd1, 5'd1, 5'd0, 3'd0, 32'd1));
        stim_q.push_back(mk(7'b001_0011, 5'd1, 5'd1, 5'd0, 3'd0, 32'd2));
        do_run(8'hFF, "wrap", 1'b0);
        if (obs_q.size() == 2) begin
            check("wrap addr0", 64'(obs_q[0].addr), 64'hFF);
            check("wrap addr1", 64'(obs_q[1].addr), 64'h00);
        end

        // Randomized runs
        for (int r = 0; r < 4; r++) begin
            stim_q.delete();
            for (int k = 0; k < 12; k++) stim_q.push_back(rand_desc());
            do_run(8'($urandom), "random", 1'b0);
        end

        // Reset during a handshake drops the in-flight write
        stim_q.delete();
        start = 1'b1; base_addr = 8'h40; n_words = 8'h03;
        tick();
        start = 1'b0;
        in_opcode = 7'b011_0011; in_imm = 32'd0; in_valid = 1'b1;
        tick();
        check("rst-run err before", 64'(err), 64'd1);
        obs_q.delete();
        in_opcode = 7'b001_0011; in_rd = 5'd1; in_imm = 32'd9;
        reset = 1'b1;
        tick();
        in_valid = 1'b0;
        check("rst-run imem_we", 64'(imem_we), 64'd0);
        check("rst-run busy", 64'(busy), 64'd0);
        check("rst-run ready", 64'(in_ready), 64'd0);
        check("rst-run done", 64'(done), 64'd0);
        check("rst-run err", 64'(err), 64'd0);
        check("rst-run err_cnt", 64'(err_cnt), 64'd0);
        check("rst-run addr", 64'(imem_addr), 64'd0);
        check("rst-run wdata", 64'(imem_wdata), 64'd0);
        reset = 1'b0;
        tick();
        tick();
        check("rst-run no write", 64'(obs_q.size()), 64'd0);
        check("rst-run idle", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/inst_encoder_loader.md
Name: inst_encoder_loader

Overview:
Inverse of the immediate generator. It packs opcode, register fields and a 32-bit immediate into a 32-bit RV32 instruction word, and range-checks the immediate against its format. A run loads a block of N accepted words into instruction memory through a write port at consecutive word addresses. It is used by the bench/boot path to fill the pipeline's instruction memory from field-level descriptions.

Parameters:
ADDR_W, 8, instruction-memory word-address width
CNT_W, 8, width of word-count input and counters

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  start a load run (sampled in IDLE only)
base_addr  in  ADDR_W  first word address of run
n_words  in  CNT_W  number of input words to consume
in_valid  in  1  field bundle valid
in_ready  out  1  block accepts bundle this cycle
in_opcode  in  7  opcode[6:0]
in_rd  in  5  rd
in_rs1  in  5  rs1
in_rs2  in  5  rs2
in_funct3  in  3  funct3
in_imm  in  32  immediate, two's complement, byte offset
imem_we  out  1  instruction-memory write strobe
imem_addr  out  ADDR_W  word address
imem_wdata  out  32  encoded instruction
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at end of run
err  out  1  sticky: any rejected word in current run
err_cnt  out  CNT_W  rejected words in current run

Behaviour:
- Reset: state IDLE. in_ready, imem_we, busy, done, err = 0. err_cnt, imem_addr, imem_wdata, all counters = 0. Any in-flight write is dropped.
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE + start: latch base_addr into the write pointer and n_words into the remaining count. Clear err and err_cnt. Go to RUN. If n_words == 0, go to DONE instead.
  - RUN: in_ready = 1 while remaining > 0. A handshake (in_valid & in_ready) consumes one word and decrements remaining. When the last word is accepted, go to FLUSH.
  - FLUSH: one cycle while the final stage-2 write issues. Then go to DONE.
  - DONE: done = 1 for exactly one cycle. Then go to IDLE.
- start is ignored outside IDLE.
- Pipeline:
  - Stage 1 (combinational, sampled on handshake): encode and check.
  - Stage 2 register: imem_we/addr/wdata.
  - Handshake at cycle N produces imem_we = 1 at cycle N+1, with imem_addr = pointer at the time of acceptance.
- The pointer increments only on valid (non-rejected) words. It wraps from 2^ADDR_W-1 to 0 silently.
- Encoding; bits [6:0] = opcode for all formats:
  - I-type (0010011, 0000011, 1100111): [31:20] = imm[11:0], [19:15] = rs1, [14:12] = funct3, [11:7] = rd. Valid iff imm[31:11] is all equal.
  - S-type (0100011): [31:25] = imm[11:5], [24:20] = rs2, [19:15] = rs1, [14:12] = funct3, [11:7] = imm[4:0]. Valid iff imm[31:11] is all equal.
  - B-type (1100011): [31] = imm[12], [30:25] = imm[10:5], [24:20] = rs2, [19:15] = rs1, [14:12] = funct3, [11:8] = imm[4:1], [7] = imm[11]. Valid iff imm[31:12] is all equal and imm[0] = 0.
  - J-type (1101111): [31] = imm[20], [30:21] = imm[10:1], [20] = imm[11], [19:12] = imm[19:12], [11:7] = rd. Valid iff imm[31:20] is all equal and imm[0] = 0.
  - Any other opcode: invalid.
- A rejected word is consumed and counts toward n_words, but it produces no write. It sets err and increments err_cnt, which saturates at all-ones.
- err and err_cnt hold their values through DONE and IDLE until the next start.
- Invariant: the decoder applied to imem_wdata reproduces in_imm exactly for every valid word.

Decomposition:
- Package inst_enc_pkg holds:
  - opcode localparams OP_JAL, OP_STORE, OP_BRANCH, OP_LOAD, OP_IMM, OP_JALR;
  - enum fmt_e {FMT_I, FMT_S, FMT_B, FMT_J, FMT_BAD};
  - enum state_e {IDLE, RUN, FLUSH, DONE}.
- One combinational sub-module, inst_field_pack. It maps opcode, fields and imm to {word, ok}. The top module holds the FSM, counters and stage-2 register.

Test Plan:
- start, base_addr = 0x10, n_words = 1; I-type opcode 0010011, rd = 1, rs1 = 0, funct3 = 0, imm = 5 -> imem_we one cycle after handshake, addr 0x10, wdata 0x00500093. done pulses; err = 0.
- Back-to-back, n_words = 3, in_valid held high:
  - S 0100011, rs1 = 1, rs2 = 2, funct3 = 2, imm = 8 -> 0x0020A423 @0x10;
  - B 1100011, rs1 = rs2 = 0, funct3 = 0, imm = -4 -> 0xFE000EE3 @0x11;
  - J 1101111, rd = 1, imm = 8 -> 0x008000EF @0x12.
  - Expect 3 consecutive write cycles and in_ready low after the third handshake.
- Range errors, n_words = 3:
  - I imm = 2048 -> rejected;
  - B imm = 3 -> rejected;
  - opcode 0110011 -> rejected.
  - Expect no writes, err = 1, err_cnt = 3, done pulse, pointer unchanged.
- n_words = 0 -> busy for 1 cycle, done the next cycle, in_ready never high. start asserted during RUN -> no effect.
- base_addr = 0xFF with ADDR_W = 8, two valid words -> writes at 0xFF, then 0x00.
- reset asserted the cycle after a handshake -> no imem_we next cycle, all outputs 0, state IDLE.
